// File: rtl/uart_tx_serializer.sv
// UART transmitter: start/data/stop framing with built-in baud-tick divider.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_tx_busy
);

  localparam int TICK_DEN = BAUD_RATE * OVERSAMPLE;
  localparam int DIV_RAW  = (CLK_FREQ + TICK_DEN / 2) / TICK_DEN;
  localparam int DIVISOR  = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int TMAX     = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int TW       = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DW-1:0]        r_div;
  logic [DW-1:0]        w_div_nxt;
  logic [TW-1:0]        r_tick;
  logic [TW-1:0]        w_tick_nxt;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_armed;
  logic                 w_armed_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 w_tick;
  logic                 w_os_last;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
  logic                 w_par_nxt;
`endif

  assign w_tick    = (r_state != S_IDLE) && (r_div == DW'(DIVISOR - 1));
  assign w_os_last = (r_tick == TW'(OVERSAMPLE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_done_nxt  = 1'b0;
    w_div_nxt   = '0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (r_state != S_IDLE && !w_tick)
      w_div_nxt = r_div + DW'(1);
    if (!i_tx_start)
      w_armed_nxt = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (i_tx_start && r_armed) begin
          w_shift_nxt = i_tx_data;
          w_armed_nxt = 1'b0;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = ^i_tx_data;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_tick_nxt = w_os_last ? '0 : r_tick + TW'(1);
          if (w_os_last)
            w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_tick_nxt = w_os_last ? '0 : r_tick + TW'(1);
          if (w_os_last) begin
            w_shift_nxt = r_shift >> 1;
            if (r_bit == BW'(DATA_BITS - 1)) begin
              w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_tick_nxt = w_os_last ? '0 : r_tick + TW'(1);
          if (w_os_last)
            w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_tick == TW'(SB_TICK - 1)) begin
            w_tick_nxt  = '0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level follows the state being entered so o_tx stays registered.
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) || w_done_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b1;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_armed <= w_armed_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_done = r_done;
  assign o_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: waveform model per frame, debugger handshake,
// start-hold, mid-frame reset and random bytes.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BIT_CLK = 160;
  localparam int FRAME   = (1 + 8 + PAR) * BIT_CLK + BIT_CLK;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tx_start = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_tx_busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  uart_tx_serializer #(
    .DATA_BITS (8),
    .CLK_FREQ  (1600),
    .BAUD_RATE (10),
    .OVERSAMPLE(16),
    .SB_TICK   (16)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_tx_start(i_tx_start),
    .i_tx_data (i_tx_data),
    .o_tx      (o_tx),
    .o_tx_done (o_tx_done),
    .o_tx_busy (o_tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the accept edge.
  function automatic logic ref_tx(input int k, input logic [7:0] b);
    int idx;
    idx = k / BIT_CLK;
    if (k >= FRAME) return 1'b1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && PAR == 1) return ^b;
    return 1'b1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit drop, input bit chk_gap);
    int wave_bad, busy_bad, n_done, done_k, idx;
    logic [7:0] got;
    logic s_start, s_stop, s_par;
    wave_bad = 0; busy_bad = 0; n_done = 0; done_k = -1;
    got = ~b; s_start = 1'b1; s_stop = 1'b0; s_par = 1'bx;
    i_tx_data  = b;
    i_tx_start = 1'b1;
    step();
    check("accept_tx", o_tx, 0);
    check("accept_busy", o_tx_busy, 1);
    if (chk_gap)
      check("gap_le2", (cyc - last_done_cyc) <= 2, 1);
    i_tx_data = ~b;
    for (int k = 0; k <= FRAME + 1; k++) begin
      if (o_tx !== ref_tx(k, b)) wave_bad++;
      if (o_tx_busy !== (k <= FRAME)) busy_bad++;
      if (o_tx_done === 1'b1) begin
        n_done++;
        done_k = k;
        last_done_cyc = cyc;
        if (drop) i_tx_start = 1'b0;
      end
      if (k % BIT_CLK == BIT_CLK / 2) begin
        idx = k / BIT_CLK;
        if (idx == 0) s_start = o_tx;
        else if (idx <= 8) got[idx-1] = o_tx;
        else if (PAR == 1 && idx == 9) s_par = o_tx;
        else s_stop = o_tx;
      end
      if (k <= FRAME) step();
    end
    check("start_bit", s_start, 0);
    check("data_byte", got, b);
    check("stop_bit", s_stop, 1);
`ifdef UART_TX_PARITY_EN
    check("parity_bit", s_par, ^b);
`endif
    check("done_count", n_done, 1);
    check("done_time", done_k, FRAME);
    check("wave_bad", wave_bad, 0);
    check("busy_bad", busy_bad, 0);
  endtask

  initial begin
    int bad;
    logic [31:0] word;
    logic [7:0] rb;

    // reset with start asserted
    i_reset = 1'b0; i_tx_start = 1'b1; i_tx_data = 8'hFF;
    bad = 0;
    repeat (5) begin
      step();
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
    end
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_tx_busy, 0);
    check("rst_done", o_tx_done, 0);
    check("rst_hold", bad, 0);
    i_tx_start = 1'b0;
    i_reset = 1'b1;
    step();

    send(8'hA5, 1'b0, 1'b0);

    // start held high after done must not resend
    bad = 0;
    repeat (2000) begin
      step();
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
    end
    check("hold_no_resend", bad, 0);
    i_tx_start = 1'b0;
    step();
    send(8'h3C, 1'b1, 1'b0);

    word = 32'hDEADBEEF;
    for (int i = 3; i >= 0; i--) begin
      rb = word[i*8 +: 8];
      send(rb, 1'b1, 1'b1);
    end

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1, 1'b1);
    end
    send(8'h07, 1'b1, 1'b1);

    // reset in the middle of data bit 4; start low mid-frame first
    rb = 8'($urandom_range(0, 255));
    i_tx_data = rb; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    bad = 0;
    for (int k = 0; k < 5 * BIT_CLK + BIT_CLK / 2; k++) begin
      if (o_tx !== ref_tx(k, rb) || o_tx_done !== 1'b0) bad++;
      step();
    end
    check("prereset_wave", bad, 0);
    i_reset = 1'b0;
    step();
    check("midrst_tx", o_tx, 1);
    check("midrst_busy", o_tx_busy, 0);
    i_reset = 1'b1;
    bad = 0;
    repeat (1700) begin
      step();
      if (o_tx !== 1'b1 || o_tx_done !== 1'b0 || o_tx_busy !== 1'b0) bad++;
    end
    check("midrst_quiet", bad, 0);
    rb = 8'($urandom_range(0, 255));
    send(rb, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
